// File: rtl/cpu_halt_dump.sv
// cpu_halt_dump
// Halt monitor and architectural-state dump engine for the 16-bit pipelined CPU.
// While the CPU runs, it counts cycles and watches the fetched instruction for
// either halt encoding. Once a halt is seen, it waits a fixed pipeline-drain
// interval. It then reads every register and every data-memory word through a
// single shared read port and streams them out on a valid/ready interface.
// Memory words equal to zero can optionally be skipped.
//
// Ports
//   clk          in   sole clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   instr        in   instruction at fetch
//   instr_valid  in   instr qualifies this cycle
//   rd_en        out  read strobe to register file / data memory
//   rd_sel       out  0 = register file, 1 = data memory
//   rd_addr      out  read address (register index zero-extended)
//   rd_data      in   read data, valid the cycle after rd_en
//   out_valid    out  dump beat available
//   out_ready    in   sink accepts beat
//   out_data     out  dumped word
//   out_addr     out  register index or memory address of out_data
//   out_is_reg   out  1 = register beat, 0 = memory beat
//   halted       out  halt seen (sticky)
//   done         out  dump complete (sticky)
//   run_cycles   out  saturating count of RUN-state cycles
//
// state   | meaning
// --------+------------------------------------------------------------
// S_RUN   | CPU running; count cycles, watch for halt encodings
// S_DRAIN | halt seen; let the pipeline drain for DRAIN_CYCLES cycles
// S_READ  | rd_en asserted for the current phase/index
// S_WAIT  | read data arrives; capture it, or skip a zero memory word
// S_EMIT  | beat presented on out_*; hold until out_ready
// S_DONE  | dump finished; terminal until reset

module cpu_halt_dump #(
    parameter int unsigned       DATA_W       = 16,
    parameter int unsigned       NUM_REGS     = 16,
    parameter int unsigned       MEM_DEPTH    = 65536,
    parameter int unsigned       DRAIN_CYCLES = 10,
    parameter logic [DATA_W-1:0] HALT_A       = 16'hE000,
    parameter logic [DATA_W-1:0] HALT_B       = 16'hE7FF,
    parameter bit                SKIP_ZERO    = 1'b1,
    parameter int unsigned       CNT_W        = 32,
    localparam int unsigned      MEM_AW       = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] instr,
    input  logic              instr_valid,
    output logic              rd_en,
    output logic              rd_sel,
    output logic [MEM_AW-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [MEM_AW-1:0] out_addr,
    output logic              out_is_reg,
    output logic              halted,
    output logic              done,
    output logic [CNT_W-1:0]  run_cycles
);

    localparam int unsigned DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRN_W-1:0]  DRN_LAST =
        DRN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
    localparam logic [MEM_AW-1:0] REG_LAST = MEM_AW'(NUM_REGS - 1);
    localparam logic [MEM_AW-1:0] MEM_LAST = MEM_AW'(MEM_DEPTH - 1);

    typedef enum logic [2:0] {
        S_RUN,
        S_DRAIN,
        S_READ,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    state_t            state;
    logic [DRN_W-1:0]  drain_cnt;
    logic              phase_mem;
    logic [MEM_AW-1:0] idx;

    logic              is_halt;
    logic [MEM_AW-1:0] idx_next;

    assign is_halt  = instr_valid && ((instr == HALT_A) || (instr == HALT_B));
    assign idx_next = idx + MEM_AW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_RUN;
            drain_cnt  <= '0;
            phase_mem  <= 1'b0;
            idx        <= '0;
            rd_en      <= 1'b0;
            rd_sel     <= 1'b0;
            rd_addr    <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_addr   <= '0;
            out_is_reg <= 1'b0;
            halted     <= 1'b0;
            done       <= 1'b0;
            run_cycles <= '0;
        end else begin
            // rd_en is a one-cycle strobe raised only on entry to S_READ
            rd_en <= 1'b0;
            case (state)
                S_RUN: begin
                    if (run_cycles != '1) begin
                        run_cycles <= run_cycles + CNT_W'(1);
                    end
                    if (is_halt) begin
                        halted    <= 1'b1;
                        drain_cnt <= '0;
                        phase_mem <= 1'b0;
                        idx       <= '0;
                        if (DRAIN_CYCLES == 0) begin
                            state   <= S_READ;
                            rd_en   <= 1'b1;
                            rd_sel  <= 1'b0;
                            rd_addr <= '0;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end
                end

                S_DRAIN: begin
                    if (drain_cnt == DRN_LAST) begin
                        state   <= S_READ;
                        rd_en   <= 1'b1;
                        rd_sel  <= 1'b0;
                        rd_addr <= '0;
                    end else begin
                        drain_cnt <= drain_cnt + DRN_W'(1);
                    end
                end

                S_READ: begin
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    if (phase_mem && SKIP_ZERO && (rd_data == '0)) begin
                        // Zero memory word: go straight to the next read, no beat
                        if (idx == MEM_LAST) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            idx     <= idx_next;
                            state   <= S_READ;
                            rd_en   <= 1'b1;
                            rd_sel  <= 1'b1;
                            rd_addr <= idx_next;
                        end
                    end else begin
                        out_data   <= rd_data;
                        out_addr   <= idx;
                        out_is_reg <= !phase_mem;
                        out_valid  <= 1'b1;
                        state      <= S_EMIT;
                    end
                end

                S_EMIT: begin
                    // out_* stay untouched while stalled; data is never re-read
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (!phase_mem && (idx == REG_LAST)) begin
                            phase_mem <= 1'b1;
                            idx       <= '0;
                            state     <= S_READ;
                            rd_en     <= 1'b1;
                            rd_sel    <= 1'b1;
                            rd_addr   <= '0;
                        end else if (phase_mem && (idx == MEM_LAST)) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            idx     <= idx_next;
                            state   <= S_READ;
                            rd_en   <= 1'b1;
                            rd_sel  <= phase_mem;
                            rd_addr <= idx_next;
                        end
                    end
                end

                S_DONE: begin
                    state <= S_DONE;
                end

                default: begin
                    state <= S_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_halt_dump.sv
// Directed bench for cpu_halt_dump. Two instances share clock, reset and the
// instruction stream:
//   dut_a: DRAIN_CYCLES=10, SKIP_ZERO=1, MEM_DEPTH=16
//   dut_b: DRAIN_CYCLES=0,  SKIP_ZERO=0, MEM_DEPTH=16
// Register i holds i+1. Memory is zero except mem[3]=1234 and mem[15]=BEEF.
module tb_cpu_halt_dump;

    typedef logic [20:0] beat_t;  // {is_reg, addr[3:0], data[15:0]}

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] instr;
    logic        instr_valid;

    logic        rd_en_a, rd_sel_a, out_valid_a, out_ready_a, out_is_reg_a, halted_a, done_a;
    logic [3:0]  rd_addr_a, out_addr_a;
    logic [15:0] rd_data_a, out_data_a;
    logic [31:0] run_cycles_a;

    logic        rd_en_b, rd_sel_b, out_valid_b, out_ready_b, out_is_reg_b, halted_b, done_b;
    logic [3:0]  rd_addr_b, out_addr_b;
    logic [15:0] rd_data_b, out_data_b;
    logic [31:0] run_cycles_b;

    logic [15:0] regs [16];
    logic [15:0] mem  [16];

    beat_t q_a[$], q_b[$], exp_a[$], exp_b[$];
    beat_t hold_beat;
    bit    hold_pend = 1'b0;
    int    stall_err = 0;

    int n_pass = 0, n_total = 0, n_fail = 0;
    int cyc = 0;
    int done_cyc_a, done_cyc_b;

    always #5 clk = ~clk;

    cpu_halt_dump #(
        .MEM_DEPTH(16), .DRAIN_CYCLES(10), .SKIP_ZERO(1'b1)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .instr(instr), .instr_valid(instr_valid),
        .rd_en(rd_en_a), .rd_sel(rd_sel_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
        .out_addr(out_addr_a), .out_is_reg(out_is_reg_a), .halted(halted_a),
        .done(done_a), .run_cycles(run_cycles_a)
    );

    cpu_halt_dump #(
        .MEM_DEPTH(16), .DRAIN_CYCLES(0), .SKIP_ZERO(1'b0)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .instr(instr), .instr_valid(instr_valid),
        .rd_en(rd_en_b), .rd_sel(rd_sel_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .out_addr(out_addr_b), .out_is_reg(out_is_reg_b), .halted(halted_b),
        .done(done_b), .run_cycles(run_cycles_b)
    );

    // Read port models: data valid only in the cycle after rd_en, junk otherwise
    always @(posedge clk) begin
        rd_data_a <= rd_en_a ? (rd_sel_a ? mem[rd_addr_a] : regs[rd_addr_a]) : 16'hDEAD;
        rd_data_b <= rd_en_b ? (rd_sel_b ? mem[rd_addr_b] : regs[rd_addr_b]) : 16'hDEAD;
    end

    // Beat capture and stall-stability monitor
    always @(posedge clk) begin
        if (!reset_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend && (out_valid_a !== 1'b1 ||
                              {out_is_reg_a, out_addr_a, out_data_a} !== hold_beat))
                stall_err++;
            hold_pend = out_valid_a && !out_ready_a;
            hold_beat = {out_is_reg_a, out_addr_a, out_data_a};
            if (out_valid_a && out_ready_a) q_a.push_back({out_is_reg_a, out_addr_a, out_data_a});
            if (out_valid_b && out_ready_b) q_b.push_back({out_is_reg_b, out_addr_b, out_data_b});
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // Edges 1..19 with non-halt traffic, including near-miss encodings
    task automatic pre_halt();
        for (int k = 1; k <= 19; k++) begin
            instr       = (k == 5) ? 16'hE001 : (k == 6) ? 16'hE000 :
                          (k == 7) ? 16'hE7FF : 16'(k * 3);
            instr_valid = (k != 6) && (k != 7);
            tick();
        end
    endtask

    task automatic cmp_q(input string nm, input beat_t got[$], input beat_t exp[$]);
        beat_t g;
        chk({nm, "_count"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            g = (i < got.size()) ? got[i] : '1;
            chk($sformatf("%s_beat%0d", nm, i), 64'(g), 64'(exp[i]));
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            regs[i] = 16'(i + 1);
            mem[i]  = 16'h0000;
        end
        mem[3]  = 16'h1234;
        mem[15] = 16'hBEEF;
        for (int i = 0; i < 16; i++) begin
            exp_a.push_back({1'b1, 4'(i), regs[i]});
            exp_b.push_back({1'b1, 4'(i), regs[i]});
        end
        for (int j = 0; j < 16; j++) begin
            if (mem[j] != 16'h0000) exp_a.push_back({1'b0, 4'(j), mem[j]});
            exp_b.push_back({1'b0, 4'(j), mem[j]});
        end

        // ---- reset values
        reset_n = 1'b0; instr = 16'h0000; instr_valid = 1'b0;
        out_ready_a = 1'b1; out_ready_b = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("rst_rd_a",   64'({rd_en_a, rd_sel_a, rd_addr_a}), 64'(0));
        chk("rst_out_a",  64'({out_valid_a, out_is_reg_a, out_addr_a, out_data_a}), 64'(0));
        chk("rst_flag_a", 64'({halted_a, done_a}), 64'(0));
        chk("rst_run_a",  64'(run_cycles_a), 64'(0));
        chk("rst_b",      64'({rd_en_b, out_valid_b, halted_b, done_b}), 64'(0));

        // ---- run 1: HALT_A at edge 20, ready always high
        reset_n = 1'b1;
        cyc = 0;
        pre_halt();
        chk("nohalt_halted_a", 64'(halted_a), 64'(0));
        chk("nohalt_run_a",    64'(run_cycles_a), 64'(19));
        chk("nohalt_halted_b", 64'(halted_b), 64'(0));
        instr = 16'hE000; instr_valid = 1'b1;
        tick();
        chk("halt_halted_a", 64'(halted_a), 64'(1));
        chk("halt_run_a",    64'(run_cycles_a), 64'(20));
        chk("halt_rden_a",   64'(rd_en_a), 64'(0));
        chk("d0_rd_b",       64'({rd_en_b, rd_sel_b, rd_addr_b}), 64'({1'b1, 1'b0, 4'd0}));
        instr = 16'hE7FF;  // halt encoding outside RUN: ignored
        while (cyc < 29) tick();
        chk("drain_rden_29", 64'(rd_en_a), 64'(0));
        tick();
        chk("first_rd_a", 64'({rd_en_a, rd_sel_a, rd_addr_a}), 64'({1'b1, 1'b0, 4'd0}));
        instr_valid = 1'b0;

        done_cyc_a = 0; done_cyc_b = 0;
        while (!(done_a && done_b) && cyc < 400) begin
            tick();
            if (done_a && done_cyc_a == 0) done_cyc_a = cyc;
            if (done_b && done_cyc_b == 0) done_cyc_b = cyc;
        end
        chk("r1_done_a",     64'(done_a), 64'(1));
        chk("r1_done_b",     64'(done_b), 64'(1));
        chk("r1_done_cyc_a", 64'(done_cyc_a), 64'(112));
        chk("r1_done_cyc_b", 64'(done_cyc_b), 64'(116));
        chk("r1_run_a",      64'(run_cycles_a), 64'(20));
        chk("r1_run_b",      64'(run_cycles_b), 64'(20));
        cmp_q("r1_a", q_a, exp_a);
        cmp_q("r1_b", q_b, exp_b);
        chk("r1_held_out_a", 64'({out_addr_a, out_data_a}), 64'({4'd15, 16'hBEEF}));
        repeat (10) tick();
        chk("r1_no_extra_a", 64'(q_a.size()), 64'(18));
        chk("r1_idle_a",     64'({out_valid_a, rd_en_a, done_a}), 64'({1'b0, 1'b0, 1'b1}));

        // ---- run 2: reset pulsed during the memory phase
        reset_n = 1'b0; instr_valid = 1'b0;
        tick();
        q_a.delete(); q_b.delete();
        reset_n = 1'b1;
        cyc = 0;
        pre_halt();
        instr = 16'hE000; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        while (rd_sel_a !== 1'b1 && cyc < 200) tick();
        chk("r2_mem_phase", 64'(rd_sel_a), 64'(1));
        #2 reset_n = 1'b0;
        #1;
        chk("r2_rst_rd_a",   64'({rd_en_a, rd_sel_a, rd_addr_a}), 64'(0));
        chk("r2_rst_out_a",  64'({out_valid_a, out_is_reg_a, out_addr_a, out_data_a}), 64'(0));
        chk("r2_rst_flag_a", 64'({halted_a, done_a}), 64'(0));
        chk("r2_rst_run_a",  64'(run_cycles_a), 64'(0));
        @(negedge clk);
        tick();

        // ---- run 3: HALT_B with random backpressure on dut_a
        q_a.delete(); q_b.delete();
        reset_n = 1'b1;
        cyc = 0;
        pre_halt();
        instr = 16'hE7FF; instr_valid = 1'b1;
        tick();
        chk("r3_halted_a", 64'(halted_a), 64'(1));
        instr_valid = 1'b0;
        while (!(done_a && done_b) && cyc < 2000) begin
            out_ready_a = 1'($urandom_range(1, 0));
            tick();
        end
        out_ready_a = 1'b1;
        chk("r3_done_a", 64'(done_a), 64'(1));
        cmp_q("r3_a", q_a, exp_a);
        cmp_q("r3_b", q_b, exp_b);
        chk("r3_stall_stable", 64'(stall_err), 64'(0));
        repeat (5) tick();
        chk("r3_idle_a", 64'({out_valid_a, q_a.size() == 18}), 64'({1'b0, 1'b1}));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cpu_halt_dump.md
# cpu_halt_dump

Parametrised halt monitor and architectural-state dump engine for the 16-bit pipelined CPU. It watches the fetched instruction stream for either halt encoding, counts RUN cycles, waits a programmable pipeline-drain interval, then walks the register file and data memory through one shared read port. Each selected word is emitted on a valid/ready stream, optionally skipping zero memory words. It replaces bench-side halt detection and state dumping with synthesizable hardware usable in simulation, emulation and silicon debug.

## Interface
- DATA_W, 16: instruction, register and memory word width
- NUM_REGS, 16: register-file entries dumped; REG_AW = $clog2(NUM_REGS)
- MEM_DEPTH, 65536: data-memory words scanned; MEM_AW = $clog2(MEM_DEPTH)
- DRAIN_CYCLES, 10: cycles between halt detection and first dump read; 0 allowed
- HALT_A, 16'hE000 / HALT_B, 16'hE7FF: halt encodings
- SKIP_ZERO, 1: 1 = suppress memory words equal to 0 (registers always emitted)
- CNT_W, 32: run-cycle counter width
- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- instr  in  DATA_W  instruction at fetch
- instr_valid  in  1  instr qualifies this cycle
- rd_en  out  1  read strobe to register file / memory
- rd_sel  out  1  0 = register file, 1 = data memory
- rd_addr  out  MEM_AW  read address (register index zero-extended)
- rd_data  in  DATA_W  read data, valid exactly one cycle after rd_en
- out_valid  out  1  dump beat available
- out_ready  in  1  sink accepts beat
- out_data  out  DATA_W  dumped word
- out_addr  out  MEM_AW  register index or memory address of out_data
- out_is_reg  out  1  beat is a register (1) or memory word (0)
- halted  out  1  halt seen; sticky until reset
- done  out  1  dump complete; sticky until reset
- run_cycles  out  CNT_W  RUN-state cycle count, saturating

## Operation
- States: RUN, DRAIN, READ, WAIT, EMIT, DONE.
- RUN: run_cycles += 1 per cycle (saturates at all-ones). Halt = instr_valid && (instr==HALT_A || instr==HALT_B). On halt: halted<=1, drain counter<=0; go DRAIN, or READ if DRAIN_CYCLES==0. Cycle of halt is counted.
- DRAIN: counter increments; when it reaches DRAIN_CYCLES-1 go READ with phase=REG, index 0.
- READ: rd_en=1, rd_sel=phase, rd_addr=index; go WAIT.
- WAIT: sample rd_data at edge. If phase=MEM, SKIP_ZERO=1 and rd_data==0: advance index, go READ (or DONE after last). Else load out_data/out_addr/out_is_reg, go EMIT.
- EMIT: out_valid=1; out_* held stable until out_ready. On out_valid&&out_ready advance: REG index NUM_REGS-1 -> phase MEM index 0; MEM index MEM_DEPTH-1 -> DONE; else index+1; go READ.
- DONE: done=1, all outputs held except out_valid=0, rd_en=0; terminal until reset.
- Halts after leaving RUN are ignored; instr is don't-care outside RUN.
- Index counters are MEM_AW wide; no wrap past MEM_DEPTH-1 (terminates instead).

## Timing
- Reset (async assert, sync-safe deassert): state RUN; rd_en, rd_sel, rd_addr, out_valid, out_data, out_addr, out_is_reg, halted, done = 0; run_cycles = 0.
- Reset mid-DRAIN/READ/WAIT/EMIT: immediate abort to reset values; pending beat discarded; next halt restarts from register 0.
- Halt sampled at edge N -> halted high after N; first rd_en in cycle N+1+DRAIN_CYCLES.
- Per emitted beat: READ, WAIT, EMIT = 3 cycles minimum; skipped zero word = 2 cycles.
- out_ready ignored unless out_valid; backpressure never re-reads memory.
- done rises the edge after final handshake (or final skipped read); no beat after done.

## Test plan
- NUM_REGS=16, MEM_DEPTH=16, DRAIN=10, SKIP_ZERO=1, reg[i]=i+1, mem[3]=16'h1234, mem[15]=16'hBEEF, HALT_A at cycle 20 -> run_cycles=20, first rd_en cycle 31, 16 register beats (addr 0..15, data 1..16) then beats (3,1234),(15,BEEF), done.
- Same setup, HALT_B, out_ready random 50% -> identical 18-beat sequence, out_* stable during stalls, no drops/duplicates.
- SKIP_ZERO=0 -> 32 beats; memory addresses 0..15 in order including zero words.
- instr=16'hE001 valid, then HALT_A with instr_valid=0 -> halted stays 0, run_cycles keeps counting.
- reset_n pulsed low during memory phase -> all outputs zero same cycle; later halt dumps again from register 0, done only after full sequence.
- DRAIN_CYCLES=0, halt at edge N -> rd_en in cycle N+1, rd_sel=0, rd_addr=0.
